sram_access_scheduler: RTL and testbench
========================================

Name: sram_access_scheduler

Overview:
- Sequences all SRAM accesses for the record/play datapath and arbitrates between two requesters.
- The record requester streams 16-bit samples into the SRAM; the play requester reads them back with a programmable stride (speed-up).
- The block owns the SRAM pins, the write/read pointers, the recorded length, and the full and play-done flags.
- It replaces ad-hoc SRAM driving in the record and play blocks with a req/ack handshake.

Parameters:
- ADDR_W, 20, SRAM word-address width; capacity is 2^ADDR_W words.
- DATA_W, 16, SRAM data width.
- READ_LAT, 1, extra wait cycles (address held, oe_n low) before read data is captured; legal range 0..3.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset.
- i_wr_req  in  1  record requester wants one word written; held until o_wr_ack.
- i_wr_data  in  DATA_W  word to write; stable while i_wr_req is high.
- o_wr_ack  out  1  one-cycle pulse: write done, or write dropped because full.
- i_rd_req  in  1  play requester wants one word; held until o_rd_valid.
- i_rd_step  in  4  read-pointer increment after each read; 0 is treated as 1.
- o_rd_data  out  DATA_W  read word, valid with o_rd_valid and held until the next read.
- o_rd_valid  out  1  one-cycle pulse completing a read request.
- i_rec_clear  in  1  clear the recording: pointers, length and flags.
- i_play_rewind  in  1  read pointer to 0; clears o_play_done.
- o_full  out  1  recording has reached capacity.
- o_play_done  out  1  read pointer has reached the recorded length.
- o_rec_len  out  ADDR_W+1  number of words recorded.
- o_sram_addr  out  ADDR_W  SRAM address.
- io_sram_dq  inout  DATA_W  SRAM data bus.
- o_sram_we_n, o_sram_ce_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n  out  1 each  SRAM controls, active-low.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - state IDLE; wr_ptr, rd_ptr, o_rec_len all 0; o_full, o_play_done, o_wr_ack, o_rd_valid all 0; o_rd_data 0; last_grant = READ.
  - SRAM pins: ce_n, we_n, oe_n = 1; dq = Z; addr 0; lb_n, ub_n = 0 at all times.
- States:
  - IDLE: SRAM deselected, dq Z.
    - If exactly one request is pending, grant it.
    - If both are pending, grant the one opposite to last_grant (round-robin). Write therefore wins first after reset.
    - A request is ignored in the same cycle its ack/valid pulse is high.
  - WRITE (1 cycle): ce_n=0, we_n=0, oe_n=1, addr=wr_ptr[ADDR_W-1:0], dq=i_wr_data.
    - Next cycle: o_wr_ack=1, wr_ptr+1, o_rec_len=wr_ptr+1, return to IDLE.
  - WRITE when o_full=1: no SRAM cycle; o_wr_ack pulses the cycle after the grant; pointers unchanged.
  - o_full is set when wr_ptr reaches 2^ADDR_W and stays set until i_rec_clear or reset.
  - READ: ce_n=0, oe_n=0, we_n=1, addr=rd_ptr.
    - Held for READ_LAT+1 cycles.
    - io_sram_dq is captured into o_rd_data on the last of those cycles.
    - Next cycle: o_rd_valid=1, return to IDLE.
  - Read latency: request seen in IDLE at cycle T gives o_rd_valid at T+2+READ_LAT.
  - Write latency: request seen in IDLE at cycle T gives o_wr_ack at T+2.
- Read pointer update (in the o_rd_valid cycle):
  - step = max(i_rd_step, 1).
  - If rd_ptr+step >= o_rec_len, then rd_ptr = o_rec_len; otherwise rd_ptr += step.
  - Arithmetic is ADDR_W+1 bits; there is no wrap.
- Read with rd_ptr >= o_rec_len, including an empty recording:
  - No SRAM access.
  - o_play_done=1.
  - o_rd_valid pulses the cycle after the grant with o_rd_data=0.
- o_play_done clears only on i_play_rewind, i_rec_clear, or reset. Writes do not clear it.
- i_rec_clear, any cycle:
  - Next cycle: wr_ptr, rd_ptr, o_rec_len = 0; o_full, o_play_done = 0.
  - An access already in flight still completes its pin cycle and its ack/valid pulse, but its pointer update is discarded.
  - Clear has priority over i_play_rewind and over any same-cycle pointer update.
- i_play_rewind, any cycle: rd_ptr=0, o_play_done=0 next cycle; it overrides a same-cycle rd_ptr update.
- Writes never stall on reads beyond one access; maximum write wait is READ_LAT+3 cycles.
- dq is driven only in the WRITE state; there is no bus contention during reads.

Decomposition:
- Package sram_sched_pkg:
  - state enum {IDLE, WRITE, READ, RESP}.
  - grant enum {GNT_WRITE, GNT_READ}.
  - SRAM idle-level constants.
- Sub-module sram_rr_pick: 2-way round-robin picker (req[1:0], last_grant → grant). Pure combinational, with last_grant registered in the parent.

Test Plan:
- Reset, then 3 writes (0xA001, 0xA002, 0xA003) → each o_wr_ack at T+2; SRAM addrs 0,1,2 with we_n low one cycle each; o_rec_len=3.
- After the above, READ_LAT=1, step=1, 4 reads → o_rd_data 0xA001, 0xA002, 0xA003 with valid at T+3; 4th read gives data 0, o_play_done=1, no ce_n low.
- Record 10 words, step=4 → reads return addrs 0,4,8; next read sets o_play_done; i_play_rewind → o_play_done=0 and the next read is addr 0.
- i_wr_req and i_rd_req held simultaneously for 6 grants → grant order W,R,W,R,W,R; no dq drive during reads.
- Force wr_ptr=2^ADDR_W−1, write twice → 1st writes addr 0xFFFFF and sets o_full; 2nd acked with no we_n pulse; o_rec_len=2^20.
- i_rec_clear asserted during READ wait → o_rd_valid still pulses; next cycle rd_ptr=0, o_rec_len=0, o_full=0.

Source files
------------

// File: rtl/sram_sched_pkg.sv
// Shared types and constants for the SRAM access scheduler: FSM states,
// requester grant encoding, SRAM pin idle levels and the read-step helper.
package sram_sched_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;
  typedef enum logic {GNT_WRITE, GNT_READ} grant_e;

  localparam logic SRAM_CTL_OFF = 1'b1;
  localparam logic SRAM_BYTE_ON = 1'b0;

  // A zero stride would stall playback forever, so it counts as one.
  function automatic logic [4:0] eff_step(input logic [3:0] step);
    return (step == 4'd0) ? 5'd1 : {1'b0, step};
  endfunction

endpackage

// File: rtl/sram_access_scheduler_if.sv
// Requester-side handshake and status bundle of the SRAM access scheduler.
// master = record/play requesters, slave = scheduler.
interface sram_access_scheduler_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16
);
  logic              i_wr_req;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_wr_ack;
  logic              i_rd_req;
  logic [3:0]        i_rd_step;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_valid;
  logic              i_rec_clear;
  logic              i_play_rewind;
  logic              o_full;
  logic              o_play_done;
  logic [ADDR_W:0]   o_rec_len;

  modport master (
    output i_wr_req, i_wr_data, i_rd_req, i_rd_step, i_rec_clear, i_play_rewind,
    input  o_wr_ack, o_rd_data, o_rd_valid, o_full, o_play_done, o_rec_len
  );

  modport slave (
    input  i_wr_req, i_wr_data, i_rd_req, i_rd_step, i_rec_clear, i_play_rewind,
    output o_wr_ack, o_rd_data, o_rd_valid, o_full, o_play_done, o_rec_len
  );
endinterface

// File: rtl/sram_rr_pick.sv
// Two-way round-robin picker: a lone request wins outright, and on a tie
// the requester that was not granted last time wins.
module sram_rr_pick
  import sram_sched_pkg::*;
(
  input  logic [1:0] req,         // [0] write, [1] read
  input  grant_e     last_grant,
  output logic       valid,
  output grant_e     grant
);

  always_comb begin
    valid = |req;
    grant = GNT_WRITE;
    case (req)
      2'b01:   grant = GNT_WRITE;
      2'b10:   grant = GNT_READ;
      2'b11:   grant = (last_grant == GNT_READ) ? GNT_WRITE : GNT_READ;
      default: grant = GNT_WRITE;
    endcase
  end

endmodule

// File: rtl/sram_access_scheduler.sv
// Owns the SRAM pins and the record/play pointers; arbitrates record writes
// and play reads through a req/ack handshake, one access at a time.
module sram_access_scheduler
  import sram_sched_pkg::*;
#(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  sram_access_scheduler_if.slave sched,
  output logic [ADDR_W-1:0]     o_sram_addr,
  inout  wire  [DATA_W-1:0]     io_sram_dq,
  output logic                  o_sram_we_n,
  output logic                  o_sram_ce_n,
  output logic                  o_sram_oe_n,
  output logic                  o_sram_lb_n,
  output logic                  o_sram_ub_n
);

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              full_q, full_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [1:0]        lat_cnt_q, lat_cnt_d;
  logic              drop_q, drop_d;

  logic              pick_valid;
  grant_e            pick_grant;
  logic [ADDR_W+1:0] rd_sum;

  sram_rr_pick u_pick (
    .req        ({sched.i_rd_req, sched.i_wr_req}),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    full_d       = full_q;
    done_d       = done_q;
    rd_data_d    = rd_data_q;
    lat_cnt_d    = lat_cnt_q;
    rd_sum       = {1'b0, rd_ptr_q} + (ADDR_W+2)'(eff_step(sched.i_rd_step));

    case (state_q)
      IDLE: begin
        lat_cnt_d = '0;
        if (pick_valid) begin
          last_grant_d = pick_grant;
          if (pick_grant == GNT_WRITE) begin
            state_d = full_q ? RESP : WRITE;
          end else if (rd_ptr_q >= wr_ptr_q) begin
            state_d   = RESP;
            rd_data_d = '0;
            done_d    = 1'b1;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        state_d = RESP;
        if (!drop_q) begin
          wr_ptr_d = wr_ptr_q + ONE;
          full_d   = (wr_ptr_d == CAP);
        end
      end
      READ: begin
        if (lat_cnt_q == 2'(READ_LAT)) begin
          rd_data_d = io_sram_dq;
          state_d   = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if ((last_grant_q == GNT_READ) && !drop_q) begin
          rd_ptr_d = (rd_sum >= {1'b0, wr_ptr_q}) ? wr_ptr_q : rd_sum[ADDR_W:0];
        end
      end
      default: state_d = IDLE;
    endcase

    // A clear seen anywhere between grant and update voids that access's pointer update.
    drop_d = (drop_q || sched.i_rec_clear) && (state_d != IDLE);

    if (sched.i_play_rewind) begin
      rd_ptr_d = '0;
      done_d   = 1'b0;
    end
    if (sched.i_rec_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      full_d   = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_READ;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      full_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_data_q    <= '0;
      lat_cnt_q    <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      full_q       <= full_d;
      done_q       <= done_d;
      rd_data_q    <= rd_data_d;
      lat_cnt_q    <= lat_cnt_d;
      drop_q       <= drop_d;
    end
  end

  always_comb begin
    o_sram_ce_n = SRAM_CTL_OFF;
    o_sram_we_n = SRAM_CTL_OFF;
    o_sram_oe_n = SRAM_CTL_OFF;
    o_sram_addr = '0;
    case (state_q)
      WRITE: begin
        o_sram_ce_n = ~SRAM_CTL_OFF;
        o_sram_we_n = ~SRAM_CTL_OFF;
        o_sram_addr = wr_ptr_q[ADDR_W-1:0];
      end
      READ: begin
        o_sram_ce_n = ~SRAM_CTL_OFF;
        o_sram_oe_n = ~SRAM_CTL_OFF;
        o_sram_addr = rd_ptr_q[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  assign o_sram_lb_n = SRAM_BYTE_ON;
  assign o_sram_ub_n = SRAM_BYTE_ON;
  assign io_sram_dq  = (state_q == WRITE) ? sched.i_wr_data : 'z;

  assign sched.o_wr_ack    = (state_q == RESP) && (last_grant_q == GNT_WRITE);
  assign sched.o_rd_valid  = (state_q == RESP) && (last_grant_q == GNT_READ);
  assign sched.o_rd_data   = rd_data_q;
  assign sched.o_full      = full_q;
  assign sched.o_play_done = done_q;
  assign sched.o_rec_len   = wr_ptr_q;

endmodule

// File: tb/tb_sram_access_scheduler.sv
// Scoreboard bench for sram_access_scheduler: a behavioural record/play model
// predicts each response; a negedge monitor checks responses and SRAM pin activity.
module tb_sram_access_scheduler;

  localparam int unsigned AW  = 4;
  localparam int unsigned DW  = 16;
  localparam int unsigned RL  = 1;
  localparam int          CAP = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_access_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_dq;
  logic          we_n, ce_n, oe_n, lb_n, ub_n;

  sram_access_scheduler #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .sched       (bus),
    .o_sram_addr (sram_addr),
    .io_sram_dq  (sram_dq),
    .o_sram_we_n (we_n),
    .o_sram_ce_n (ce_n),
    .o_sram_oe_n (oe_n),
    .o_sram_lb_n (lb_n),
    .o_sram_ub_n (ub_n)
  );

  // Asynchronous SRAM device
  logic [DW-1:0] sram_mem [CAP];
  assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr] : 'z;
  always @(posedge clk) if (!ce_n && !we_n) sram_mem[sram_addr] <= sram_dq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit is_rd;
    int data;
    int lat;     // -1: not checked
    int n_acc;   // SRAM cycles expected for this access
    int addr;
    int len;
    bit full;
    bit done;
    int issue;
  } exp_t;

  exp_t sb[$];

  // Reference model of the recording
  int ref_mem [CAP];
  int ref_len = 0;
  int ref_rd = 0;
  bit ref_full = 0;
  bit ref_done = 0;
  bit ref_last_rd = 1;

  function automatic exp_t model_write(input int d);
    exp_t e;
    e.is_rd = 0; e.data = d; e.issue = 0; e.addr = 0;
    if (ref_full) begin
      e.lat = 1; e.n_acc = 0;
    end else begin
      e.lat = 2; e.n_acc = 1; e.addr = ref_len;
      ref_mem[ref_len] = d;
      ref_len++;
      ref_full = (ref_len == CAP);
    end
    ref_last_rd = 0;
    e.len = ref_len; e.full = ref_full; e.done = ref_done;
    return e;
  endfunction

  function automatic exp_t model_read(input int step);
    exp_t e;
    int s;
    s = (step == 0) ? 1 : step;
    e.is_rd = 1; e.issue = 0; e.addr = 0;
    if (ref_rd >= ref_len) begin
      e.lat = 1; e.n_acc = 0; e.data = 0;
      ref_done = 1;
    end else begin
      e.lat = 2 + RL; e.n_acc = RL + 1; e.addr = ref_rd;
      e.data = ref_mem[ref_rd];
      ref_rd = (ref_rd + s >= ref_len) ? ref_len : ref_rd + s;
    end
    ref_last_rd = 1;
    e.len = ref_len; e.full = ref_full; e.done = ref_done;
    return e;
  endfunction

  function automatic void model_clear();
    ref_len = 0; ref_rd = 0; ref_full = 0; ref_done = 0;
  endfunction

  // Monitor: accumulates SRAM activity, checks each response against the scoreboard
  int   we_cnt = 0, rd_cnt = 0, w_addr = 0, r_addr = 0, w_data = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      we_cnt = 0; rd_cnt = 0;
    end else begin
      if (!ce_n && !we_n) begin we_cnt++; w_addr = int'(sram_addr); w_data = int'(sram_dq); end
      if (!ce_n && !oe_n) begin rd_cnt++; r_addr = int'(sram_addr); end
      if (bus.o_wr_ack || bus.o_rd_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_response", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_kind", int'(bus.o_rd_valid), int'(mon_e.is_rd));
          chk("one_pulse", int'(bus.o_wr_ack & bus.o_rd_valid), 0);
          if (mon_e.lat >= 0) chk("latency", cyc - mon_e.issue, mon_e.lat);
          if (mon_e.is_rd) begin
            chk("rd_data", int'(bus.o_rd_data), mon_e.data);
            chk("rd_sram_cycles", rd_cnt, mon_e.n_acc);
            if (mon_e.n_acc > 0) chk("rd_addr", r_addr, mon_e.addr);
            chk("we_during_read", we_cnt, 0);
          end else begin
            chk("wr_sram_cycles", we_cnt, mon_e.n_acc);
            if (mon_e.n_acc > 0) begin
              chk("wr_addr", w_addr, mon_e.addr);
              chk("wr_dq", w_data, mon_e.data);
            end
            chk("oe_during_write", rd_cnt, 0);
          end
          chk("rec_len", int'(bus.o_rec_len), mon_e.len);
          chk("full", int'(bus.o_full), int'(mon_e.full));
          chk("play_done", int'(bus.o_play_done), int'(mon_e.done));
        end
        we_cnt = 0; rd_cnt = 0;
      end
    end
  end

  task automatic wait_resp(input bit rd, input string nm);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (rd ? bus.o_rd_valid : bus.o_wr_ack) seen = 1;
    end
    chk(nm, int'(seen), 1);
  endtask

  task automatic do_write(input int d);
    exp_t e;
    @(posedge clk); #1;
    e = model_write(d);
    e.issue = cyc;
    sb.push_back(e);
    bus.i_wr_data = DW'(d);
    bus.i_wr_req  = 1'b1;
    wait_resp(0, "wr_ack_seen");
    @(posedge clk); #1;
    bus.i_wr_req = 1'b0;
  endtask

  task automatic do_read(input int step);
    exp_t e;
    @(posedge clk); #1;
    e = model_read(step);
    e.issue = cyc;
    sb.push_back(e);
    bus.i_rd_step = 4'(step);
    bus.i_rd_req  = 1'b1;
    wait_resp(1, "rd_valid_seen");
    @(posedge clk); #1;
    bus.i_rd_req = 1'b0;
  endtask

  task automatic do_rewind();
    @(posedge clk); #1;
    bus.i_play_rewind = 1'b1;
    ref_rd = 0; ref_done = 0;
    @(posedge clk); #1;
    bus.i_play_rewind = 1'b0;
    chk("rewind_done", int'(bus.o_play_done), 0);
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    bus.i_rec_clear = 1'b1;
    model_clear();
    @(posedge clk); #1;
    bus.i_rec_clear = 1'b0;
    chk("clear_len", int'(bus.o_rec_len), 0);
    chk("clear_full", int'(bus.o_full), 0);
    chk("clear_done", int'(bus.o_play_done), 0);
  endtask

  task automatic clear_during_read();
    exp_t e;
    @(posedge clk); #1;
    e = model_read(1);
    model_clear();
    e.len = 0; e.full = 0; e.done = 0;
    e.issue = cyc;
    sb.push_back(e);
    bus.i_rd_step = 4'd1;
    bus.i_rd_req  = 1'b1;
    @(posedge clk); #1;
    bus.i_rec_clear = 1'b1;
    @(posedge clk); #1;
    bus.i_rec_clear = 1'b0;
    wait_resp(1, "rd_valid_after_clear");
    @(posedge clk); #1;
    bus.i_rd_req = 1'b0;
    chk("clear_len", int'(bus.o_rec_len), 0);
    chk("clear_full", int'(bus.o_full), 0);
  endtask

  task automatic both_requesters();
    int wd [3];
    int iw = 0;
    exp_t e;
    bit pick_rd;
    for (int i = 0; i < 3; i++) wd[i] = int'($urandom_range(0, 65535));
    for (int k = 0; k < 6; k++) begin
      if (iw < 3 && (k - iw) < 3) pick_rd = !ref_last_rd;
      else pick_rd = (iw >= 3);
      if (pick_rd) e = model_read(1);
      else begin e = model_write(wd[iw]); iw++; end
      e.lat = -1;
      sb.push_back(e);
    end
    fork
      begin
        @(posedge clk); #1;
        bus.i_wr_data = DW'(wd[0]);
        bus.i_wr_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
          wait_resp(0, "rr_wr_ack_seen");
          @(posedge clk); #1;
          if (i < 2) bus.i_wr_data = DW'(wd[i+1]);
          else bus.i_wr_req = 1'b0;
        end
      end
      begin
        @(posedge clk); #1;
        bus.i_rd_step = 4'd1;
        bus.i_rd_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
          wait_resp(1, "rr_rd_valid_seen");
          @(posedge clk); #1;
          if (i == 2) bus.i_rd_req = 1'b0;
        end
      end
    join
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst = 1'b1;
    bus.i_wr_req = 1'b0; bus.i_wr_data = '0; bus.i_rd_req = 1'b0; bus.i_rd_step = '0;
    bus.i_rec_clear = 1'b0; bus.i_play_rewind = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_rec_len", int'(bus.o_rec_len), 0);
    chk("rst_full", int'(bus.o_full), 0);
    chk("rst_play_done", int'(bus.o_play_done), 0);
    chk("rst_wr_ack", int'(bus.o_wr_ack), 0);
    chk("rst_rd_valid", int'(bus.o_rd_valid), 0);
    chk("rst_rd_data", int'(bus.o_rd_data), 0);
    chk("rst_ce_n", int'(ce_n), 1);
    chk("rst_we_n", int'(we_n), 1);
    chk("rst_oe_n", int'(oe_n), 1);
    chk("rst_addr", int'(sram_addr), 0);
    chk("rst_lb_ub", int'({lb_n, ub_n}), 0);

    do_write(16'hA001);
    do_write(16'hA002);
    do_write(16'hA003);
    for (int i = 0; i < 4; i++) do_read(1);

    do_clear();
    for (int i = 0; i < 10; i++) do_write(int'($urandom_range(0, 65535)));
    for (int i = 0; i < 4; i++) do_read(4);
    do_rewind();
    do_read(4);

    do_clear();
    both_requesters();

    do_clear();
    for (int i = 0; i < CAP + 1; i++) do_write(int'($urandom_range(0, 65535)));
    clear_during_read();
    do_write(16'h1234);
    do_write(16'h5678);
    do_read(1);

    for (int i = 0; i < 120; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45) do_write(int'($urandom_range(0, 65535)));
      else if (r < 88) do_read(int'($urandom_range(0, 15)));
      else if (r < 94) do_rewind();
      else do_clear();
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
